// File: rtl/sequence_ram_ctrl.sv
// Sequence RAM controller: records player entries into a 16x4 synchronous RAM
// and plays them back on the LEDs with a programmable on-time and blank gap.
module sequence_ram_ctrl #(
    parameter int TICKS_ON  = 3,
    parameter int TICKS_OFF = 2,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       record,
    input  logic [3:0] last_addr,
    input  logic [3:0] rec_data,
    input  logic       rec_valid,
    input  logic [3:0] ram_q,
    output logic [3:0] ram_addr,
    output logic [3:0] ram_data,
    output logic       ram_we,
    output logic [3:0] leds,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHOW,
        GAP,
        REC,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(TICKS_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(TICKS_OFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    logic [3:0]       idx_q;
    logic [3:0]       last_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        idx_q   <= '0;
                        last_q  <= last_addr;
                    end else if (record) begin
                        state_q <= REC;
                        idx_q   <= '0;
                        last_q  <= last_addr;
                    end
                end
                // The address is already on the RAM; this cycle absorbs its read latency.
                FETCH: begin
                    state_q <= SHOW;
                    cnt_q   <= '0;
                end
                SHOW: begin
                    if (cnt_q == ON_LAST) begin
                        state_q <= GAP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_q == OFF_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == last_q) begin
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= FETCH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                REC: begin
                    if (rec_valid) begin
                        if (idx_q == last_q) begin
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr = idx_q;
    assign ram_data = rec_data;
    // Writing is gated by reset so an in-flight record pulse never lands during reset.
    assign ram_we   = (state_q == REC) && rec_valid && !reset;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    always_comb begin
        leds = 4'h0;
        case (state_q)
            SHOW:    leds = ram_q;
            REC:     leds = rec_valid ? rec_data : 4'h0;
            default: leds = 4'h0;
        endcase
    end

endmodule
